m31_addsub_vec: RTL and testbench
=================================

Name: m31_addsub_vec

Overview:
- Pipelined, multi-lane M31 (p = 2^31-1) modular add/subtract/negate unit with valid/ready flow control and a passthrough tag.
- Generalises the single-lane combinational M31 adder: LANES independent lanes, a per-transaction opcode, selectable pipeline depth and full backpressure.
- Used by the Poseidon2 round datapath (round-constant add, MDS accumulation, state subtraction) between the state register file and the S-box/MDS stages.

Parameters:
- LANES, 16, number of parallel M31 lanes; integer >= 1.
- STAGES, 2, pipeline depth; legal values 1 or 2; any other value is an elaboration error.
- TAG_W, 8, width of the opaque tag carried alongside each transaction; integer >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid_i  in  1  input transaction valid.
- in_ready_o  out  1  unit can accept an input transaction this cycle.
- op_i  in  2  operation: 00 ADD (a+b), 01 SUB (a-b), 10 NEG (-b), 11 reserved.
- a_i  in  LANES*31  lane k occupies bits [31k+30:31k].
- b_i  in  LANES*31  same packing as a_i.
- tag_i  in  TAG_W  opaque tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- res_o  out  LANES*31  canonical results, same packing as a_i.
- tag_o  out  TAG_W  tag of the transaction currently on res_o.
- err_o  out  1  the transaction on res_o used op 11.

Behaviour:
- Handshake: a transfer occurs when valid and ready are both high on a rising edge.
  - While valid is high and ready is low, the producer holds op_i, a_i, b_i and tag_i stable.
  - While out_valid_o is high and out_ready_i is low, the unit holds res_o, tag_o and err_o stable.
- Latency: an input accepted at edge N produces out_valid_o high after edge N+STAGES-1 (STAGES=1: visible after the same edge). This assumes no stall.
- Throughput: one transaction per cycle when out_ready_i is held high.
- Stall rule: each stage register loads when it is empty or when its contents advance this cycle.
  - in_ready_o = !s0_valid | s0_advance.
  - The last stage advances when out_ready_i is high.
  - No bubbles are inserted. No data is lost or duplicated under any valid/ready pattern.
- Input domain: each 31-bit operand is in [0, p]. The value p is congruent to 0 and is treated as 0.
- Per-lane arithmetic:
  - ADD: s = {0,a}+{0,b} (32 bits).
  - SUB: s = {0,a}+{0,~b}, where ~b is the 31-bit inversion, equal to p-b.
  - NEG: s = {0,~b}; a is ignored.
  - Fold: f = s[30:0] + s[31] (31-bit result, no further carry possible).
  - Canonicalise: r = (f == p) ? 0 : f.
  - Every output lane is in [0, p-1].
- Op 11: all lanes of res_o are 0 and err_o = 1. The transaction still flows through the pipeline and the handshake like any other; it is not dropped.
- Stage split:
  - STAGES=2: stage 0 registers the 32-bit sum s per lane, plus tag and err. Stage 1 registers the folded, canonicalised r.
  - STAGES=1: s, f and r are computed combinationally and registered once.
- The tag propagates with its data unchanged.
- Reset (synchronous):
  - All stage valid bits clear.
  - out_valid_o = 0, res_o = 0, tag_o = 0, err_o = 0.
  - in_ready_o = 1 from the first cycle after reset deasserts.
- Reset mid-operation: all in-flight transactions are discarded. No transfer completes on a cycle where rst is high, whatever the state of valid and ready.
- Simultaneous accept and emit at the same stage is legal and keeps the pipeline full.

Test Plan:
- ADD lane0 a=0x7FFFFFFE, b=1 -> res lane0 = 0 (f == p case). ADD a=b=0x7FFFFFFE -> 0x7FFFFFFD. ADD a=p, b=5 -> 5.
- SUB a=5, b=7 -> 0x7FFFFFFD. SUB a=7, b=7 -> 0. SUB a=0, b=p -> 0. NEG b=0 -> 0. NEG b=1 -> 0x7FFFFFFE.
- Op 11 with tag 0x5A -> res = 0 on all lanes, err_o = 1, tag_o = 0x5A. The next ADD 1+2 has err_o = 0 and result 3.
- Streaming with out_ready_i high, 100 random back-to-back ops on all lanes:
  - One result per cycle after STAGES-cycle latency.
  - Results and tags match a golden model computed as (a±b) mod p.
- Backpressure: out_ready_i low for 3 cycles while 3 inputs are offered:
  - Outputs stay stable.
  - in_ready_o drops once all STAGES registers are full.
  - After release, results emerge in order with no loss or duplication.
- Assert rst for 1 cycle with 2 transactions in flight -> out_valid_o = 0 on the next cycle, in_ready_o = 1, and no stale result appears afterwards.
- Run all of the above at STAGES=1 and STAGES=2, LANES=1 and LANES=16.

Source files
------------

// File: rtl/m31_addsub_vec.sv
// Multi-lane M31 (p = 2^31-1) add/sub/negate pipeline with valid/ready flow control.
// Each stage register loads when empty or when its contents move on, so the pipe stays full under stalls.
module m31_addsub_vec #(
  parameter int LANES  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [1:0]          op_i,
  input  logic [LANES*31-1:0] a_i,
  input  logic [LANES*31-1:0] b_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [LANES*31-1:0] res_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic                err_o
);
  localparam logic [30:0] P = 31'h7FFF_FFFF;

  // Reserved op yields a zero sum, which folds to a zero result.
  function automatic logic [31:0] m31_sum(input logic [1:0] op, input logic [30:0] a,
                                          input logic [30:0] b);
    case (op)
      2'b00:   m31_sum = {1'b0, a} + {1'b0, b};
      2'b01:   m31_sum = {1'b0, a} + {1'b0, ~b};
      2'b10:   m31_sum = {1'b0, ~b};
      default: m31_sum = '0;
    endcase
  endfunction

  function automatic logic [30:0] m31_fold(input logic [31:0] s);
    logic [30:0] f;
    f = s[30:0] + {30'd0, s[31]};
    m31_fold = (f == P) ? '0 : f;
  endfunction

  logic [LANES*32-1:0] w_sum;
  logic                w_err;

  assign w_err = (op_i == 2'b11);

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < LANES; k++)
      w_sum[32*k +: 32] = m31_sum(op_i, a_i[31*k +: 31], b_i[31*k +: 31]);
  end

  if (STAGES == 1) begin : g_one
    logic [LANES*31-1:0] w_res;
    logic                r_valid;
    logic [LANES*31-1:0] r_res;
    logic [TAG_W-1:0]    r_tag;
    logic                r_err;

    always_comb begin
      w_res = '0;
      for (int k = 0; k < LANES; k++)
        w_res[31*k +: 31] = m31_fold(w_sum[32*k +: 32]);
    end

    assign in_ready_o = !r_valid || out_ready_i;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_res   <= '0;
        r_tag   <= '0;
        r_err   <= 1'b0;
      end else if (in_ready_o) begin
        r_valid <= in_valid_i;
        r_res   <= w_res;
        r_tag   <= tag_i;
        r_err   <= w_err;
      end
    end

    assign out_valid_o = r_valid;
    assign res_o       = r_res;
    assign tag_o       = r_tag;
    assign err_o       = r_err;
  end else if (STAGES == 2) begin : g_two
    logic                r_s0_valid;
    logic [LANES*32-1:0] r_s0_sum;
    logic [TAG_W-1:0]    r_s0_tag;
    logic                r_s0_err;
    logic                r_s1_valid;
    logic [LANES*31-1:0] r_s1_res;
    logic [TAG_W-1:0]    r_s1_tag;
    logic                r_s1_err;
    logic                w_s0_load;
    logic                w_s1_load;
    logic [LANES*31-1:0] w_res;

    // !v | (v & next_load) reduces to !v | next_load.
    assign w_s1_load  = !r_s1_valid || out_ready_i;
    assign w_s0_load  = !r_s0_valid || w_s1_load;
    assign in_ready_o = w_s0_load;

    always_comb begin
      w_res = '0;
      for (int k = 0; k < LANES; k++)
        w_res[31*k +: 31] = m31_fold(r_s0_sum[32*k +: 32]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s0_valid <= 1'b0;
        r_s0_sum   <= '0;
        r_s0_tag   <= '0;
        r_s0_err   <= 1'b0;
        r_s1_valid <= 1'b0;
        r_s1_res   <= '0;
        r_s1_tag   <= '0;
        r_s1_err   <= 1'b0;
      end else begin
        if (w_s0_load) begin
          r_s0_valid <= in_valid_i;
          r_s0_sum   <= w_sum;
          r_s0_tag   <= tag_i;
          r_s0_err   <= w_err;
        end
        if (w_s1_load) begin
          r_s1_valid <= r_s0_valid;
          r_s1_res   <= w_res;
          r_s1_tag   <= r_s0_tag;
          r_s1_err   <= r_s0_err;
        end
      end
    end

    assign out_valid_o = r_s1_valid;
    assign res_o       = r_s1_res;
    assign tag_o       = r_s1_tag;
    assign err_o       = r_s1_err;
  end else begin : g_bad
    $error("m31_addsub_vec: STAGES must be 1 or 2");
  end

endmodule

// File: tb/tb_m31_addsub_vec.sv
// Bench for m31_addsub_vec: four instances (STAGES 1/2 x LANES 1/16), each with a
// scoreboard driven by a modular-arithmetic reference and directed literal checks.
module tb_m31_addsub_vec;
  localparam int     TAG_W = 8;
  localparam longint PM    = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done[4];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic longint m31_ref(input int op, input longint a, input longint b);
    longint x, y;
    x = a % PM;
    y = b % PM;
    case (op)
      0:       return (x + y) % PM;
      1:       return (x - y + PM) % PM;
      2:       return (PM - y) % PM;
      default: return 0;
    endcase
  endfunction

  function automatic logic [30:0] rnd31();
    logic [30:0] v;
    v = 31'($urandom());
    if ($urandom_range(0, 15) == 0) v = 31'h7FFF_FFFF;
    return v;
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_cfg
    localparam int S = (c < 2) ? 1 : 2;
    localparam int L = (c % 2 == 0) ? 1 : 16;

    logic             rst, in_valid, in_ready, out_valid, out_ready, err;
    logic [1:0]       op;
    logic [L*31-1:0]  a, b, res;
    logic [TAG_W-1:0] tag_in, tag_out;

    m31_addsub_vec #(.LANES(L), .STAGES(S), .TAG_W(TAG_W)) u_dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .op_i(op), .a_i(a), .b_i(b), .tag_i(tag_in),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .res_o(res), .tag_o(tag_out), .err_o(err)
    );

    logic [L*31-1:0]  q_res[$];
    logic [TAG_W-1:0] q_tag[$];
    logic             q_err[$];
    int               out_cnt = 0;
    logic             hold_pending = 1'b0;
    logic [L*31-1:0]  h_res;
    logic [TAG_W-1:0] h_tag;
    logic             h_err;

    task automatic chk(input string nm, input longint act, input longint exp);
      check($sformatf("c%0d_%s", c, nm), act, exp);
    endtask

    function automatic logic [L*31-1:0] model(input logic [1:0] o, input logic [L*31-1:0] av,
                                              input logic [L*31-1:0] bv);
      logic [L*31-1:0] r;
      longint          v;
      r = '0;
      for (int k = 0; k < L; k++) begin
        v = m31_ref(int'(o), longint'(av[31*k +: 31]), longint'(bv[31*k +: 31]));
        r[31*k +: 31] = v[30:0];
      end
      return r;
    endfunction

    // Inputs change #1 after posedge, so the negedge view equals what the next edge sees.
    always @(negedge clk) begin
      if (rst) begin
        q_res.delete();
        q_tag.delete();
        q_err.delete();
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          chk("hold_res", (res === h_res) ? 1 : 0, 1);
          chk("hold_tag", longint'(tag_out), longint'(h_tag));
          chk("hold_err", longint'(err), longint'(h_err));
        end
        if (out_valid && out_ready) begin
          if (q_res.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            logic [L*31-1:0] er;
            er = q_res.pop_front();
            for (int k = 0; k < L; k++)
              chk($sformatf("res_l%0d", k), longint'(res[31*k +: 31]), longint'(er[31*k +: 31]));
            chk("tag", longint'(tag_out), longint'(q_tag.pop_front()));
            chk("err", longint'(err), longint'(q_err.pop_front()));
          end
          out_cnt++;
        end
        if (in_valid && in_ready) begin
          q_res.push_back(model(op, a, b));
          q_tag.push_back(tag_in);
          q_err.push_back(op == 2'b11);
        end
        hold_pending = out_valid && !out_ready;
        h_res = res;
        h_tag = tag_out;
        h_err = err;
      end
    end

    task automatic drive(input logic [1:0] o, input logic [30:0] av, input logic [30:0] bv,
                         input logic [TAG_W-1:0] t);
      op = o;
      a = {L{av}};
      b = {L{bv}};
      tag_in = t;
    endtask

    task automatic send(input logic [1:0] o, input logic [30:0] av, input logic [30:0] bv,
                        input logic [TAG_W-1:0] t);
      int n;
      n = 0;
      drive(o, av, bv, t);
      in_valid = 1'b1;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        n++;
        if (n > 50) begin
          chk("accept_timeout", n, 0);
          break;
        end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [1:0] o, input logic [30:0] av, input logic [30:0] bv,
                           input logic [TAG_W-1:0] t, input logic [30:0] exp0, input logic experr);
      int lat;
      send(o, av, bv, t);
      lat = 0;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1 lat++;
      end
      chk("latency", lat, S - 1);
      chk("lit_res", longint'(res[30:0]), longint'(exp0));
      chk("lit_tag", longint'(tag_out), longint'(t));
      chk("lit_err", longint'(err), longint'(experr));
      @(posedge clk);
      #1;
    endtask

    task automatic drain(output int n);
      n = 0;
      while (q_res.size() != 0 && n < 30) begin
        @(posedge clk);
        #1 n++;
      end
      chk("drained", q_res.size(), 0);
    endtask

    initial begin
      int stalls, n, acc, base;
      logic [1:0]       vo[3];
      logic [L*31-1:0]  va[3], vb[3];
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; a = '0; b = '0; tag_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_res", (res == '0) ? 1 : 0, 1);
      chk("rst_tag", longint'(tag_out), 0);
      chk("rst_err", longint'(err), 0);
      chk("rst_in_ready", longint'(in_ready), 1);

      run_one(2'b00, 31'h7FFF_FFFE, 31'd1,        8'h01, 31'd0,         1'b0);
      run_one(2'b00, 31'h7FFF_FFFE, 31'h7FFF_FFFE, 8'h02, 31'h7FFF_FFFD, 1'b0);
      run_one(2'b00, 31'h7FFF_FFFF, 31'd5,        8'h03, 31'd5,         1'b0);
      run_one(2'b01, 31'd5,         31'd7,        8'h04, 31'h7FFF_FFFD, 1'b0);
      run_one(2'b01, 31'd7,         31'd7,        8'h05, 31'd0,         1'b0);
      run_one(2'b01, 31'd0,         31'h7FFF_FFFF, 8'h06, 31'd0,         1'b0);
      run_one(2'b10, 31'd9,         31'd0,        8'h07, 31'd0,         1'b0);
      run_one(2'b10, 31'd9,         31'd1,        8'h08, 31'h7FFF_FFFE, 1'b0);
      run_one(2'b11, 31'd123,       31'd456,      8'h5A, 31'd0,         1'b1);
      run_one(2'b00, 31'd1,         31'd2,        8'h09, 31'd3,         1'b0);

      // Back-to-back stream with the output always ready.
      stalls = 0;
      base = out_cnt;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
        op = 2'($urandom_range(0, 3));
        for (int k = 0; k < L; k++) begin
          a[31*k +: 31] = rnd31();
          b[31*k +: 31] = rnd31();
        end
        tag_in = 8'(i);
        @(negedge clk);
        if (!in_ready) stalls++;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      chk("stream_stalls", stalls, 0);
      drain(n);
      chk("stream_tail", n, S);
      chk("stream_count", out_cnt - base, 100);

      // Backpressure: three offered while the output is blocked.
      for (int i = 0; i < 3; i++) begin
        vo[i] = 2'($urandom_range(0, 2));
        for (int k = 0; k < L; k++) begin
          va[i][31*k +: 31] = rnd31();
          vb[i][31*k +: 31] = rnd31();
        end
      end
      base = out_cnt;
      acc = 0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 3; cyc++) begin
        op = vo[acc]; a = va[acc]; b = vb[acc]; tag_in = 8'(8'hA0 + acc);
        @(negedge clk);
        if (in_ready) acc++;
        @(posedge clk);
        #1;
      end
      chk("bp_accepted", acc, S);
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_out_valid", longint'(out_valid), 1);
      out_ready = 1'b1;
      n = 0;
      while (acc < 3 && n < 20) begin
        op = vo[acc]; a = va[acc]; b = vb[acc]; tag_in = 8'(8'hA0 + acc);
        @(negedge clk);
        if (in_ready) acc++;
        @(posedge clk);
        #1 n++;
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", acc, 3);
      drain(n);
      chk("bp_out_count", out_cnt - base, 3);

      // Reset with transactions in flight.
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
        drive(2'b00, 31'(10 + i), 31'd20, 8'(8'hC0 + i));
        @(posedge clk);
        #1;
      end
      rst = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      in_valid = 1'b0;
      chk("mid_rst_out_valid", longint'(out_valid), 0);
      chk("mid_rst_in_ready", longint'(in_ready), 1);
      chk("mid_rst_res", (res == '0) ? 1 : 0, 1);
      chk("mid_rst_tag", longint'(tag_out), 0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk);
        #1 if (out_valid) n++;
      end
      chk("stale_after_rst", n, 0);

      run_one(2'b01, 31'd100, 31'd1, 8'h77, 31'd99, 1'b0);
      done[c] = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2] && done[3]) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) check("global_timeout", n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
